// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the round-robin data-memory arbiter.
// The state encoding is fixed so that waveforms and dumps stay comparable across revisions.
package dmem_arbiter_pkg;

  localparam int DefNumCores = 4;
  localparam int DefWidth    = 12;
  localparam int DefDepth    = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_DONE   = 2'd3
  } arbState_e;

  // Increment an index and wrap it back to zero at the modulus.
  function automatic int wrapInc(input int idx, input int modulus);
    return (idx + 1 >= modulus) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side bus of the data-memory arbiter: flattened per-core requests in, shared ack/rdata out.
// The cores drive through the master modport; the arbiter sits on the slave modport.
interface dmem_arbiter_if #(
  parameter int NUM_CORES  = 4,
  parameter int WIDTH      = 12,
  parameter int ADDR_WIDTH = 10
);

  logic [NUM_CORES-1:0]            req;
  logic [NUM_CORES-1:0]            writeEn;
  logic [NUM_CORES*ADDR_WIDTH-1:0] addr;
  logic [NUM_CORES*WIDTH-1:0]      wdata;
  logic [NUM_CORES-1:0]            coreDone;
  logic [NUM_CORES-1:0]            ack;
  logic [WIDTH-1:0]                rdata;

  modport master (
    output req, writeEn, addr, wdata, coreDone,
    input  ack, rdata
  );

  modport slave (
    input  req, writeEn, addr, wdata, coreDone,
    output ack, rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first requester found scanning up from ptr,
// wrapping modulo NUM_CORES.
module rr_picker
  import dmem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int SEL_WIDTH = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic                 grantValid_o,
  output logic [SEL_WIDTH-1:0] grantIdx_o
);

  // Walk from the farthest offset back toward ptr so the nearest requester is written last.
  always_comb begin
    int idx;
    grantValid_o = 1'b0;
    grantIdx_o   = '0;
    idx          = 0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_CORES) begin
        idx = idx - NUM_CORES;
      end
      if (req_i[SEL_WIDTH'(idx)]) begin
        grantValid_o = 1'b1;
        grantIdx_o   = SEL_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter serialising NUM_CORES cores onto one single-port data memory,
// sequencing its 1-cycle write / 2-cycle read timing and returning a one-cycle ack.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = DefNumCores,
  parameter int WIDTH      = DefWidth,
  parameter int DEPTH      = DefDepth,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int SEL_WIDTH  = $clog2(NUM_CORES)
) (
  input  logic                  clock,
  input  logic                  reset,
  dmem_arbiter_if.slave         bus,
  output logic                  mem_writeEn,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0]      mem_dataIn,
  input  logic [WIDTH-1:0]      mem_dataOut,
  output logic                  processDone
);

  arbState_e stateQ, stateD;

  logic [SEL_WIDTH-1:0]  ptrQ, ptrD;
  logic [SEL_WIDTH-1:0]  selQ, selD;
  logic [NUM_CORES-1:0]  ackQ, ackD;
  logic [WIDTH-1:0]      rdataQ, rdataD;
  logic                  memWeQ, memWeD;
  logic [ADDR_WIDTH-1:0] memAddrQ, memAddrD;
  logic [WIDTH-1:0]      memDataQ, memDataD;
  logic                  procDoneQ;

  logic                  grantValid;
  logic [SEL_WIDTH-1:0]  grantIdx;
  logic                  grantWrite;
  logic [ADDR_WIDTH-1:0] grantAddr;
  logic [WIDTH-1:0]      grantData;

  rr_picker #(
    .NUM_CORES (NUM_CORES),
    .SEL_WIDTH (SEL_WIDTH)
  ) picker (
    .req_i        (bus.req),
    .ptr_i        (ptrQ),
    .grantValid_o (grantValid),
    .grantIdx_o   (grantIdx)
  );

  // Select the winning core's slice out of the flattened request buses.
  always_comb begin
    grantWrite = 1'b0;
    grantAddr  = '0;
    grantData  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grantIdx == SEL_WIDTH'(i)) begin
        grantWrite = bus.writeEn[i];
        grantAddr  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        grantData  = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Everything the winner needs is captured at grant, so a core dropping req afterwards
  // cannot disturb its own access.
  always_comb begin
    stateD   = stateQ;
    ptrD     = ptrQ;
    selD     = selQ;
    ackD     = ackQ;
    rdataD   = rdataQ;
    memWeD   = memWeQ;
    memAddrD = memAddrQ;
    memDataD = memDataQ;
    unique case (stateQ)
      ST_IDLE: begin
        if (grantValid) begin
          selD     = grantIdx;
          memAddrD = grantAddr;
          memDataD = grantData;
          memWeD   = grantWrite;
          stateD   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        memWeD = 1'b0;
        if (memWeQ) begin
          ackD   = NUM_CORES'(1) << selQ;
          stateD = ST_DONE;
        end else begin
          stateD = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        rdataD = mem_dataOut;
        ackD   = NUM_CORES'(1) << selQ;
        stateD = ST_DONE;
      end
      ST_DONE: begin
        ackD   = '0;
        ptrD   = SEL_WIDTH'(wrapInc(int'(selQ), NUM_CORES));
        stateD = ST_IDLE;
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ    <= ST_IDLE;
      ptrQ      <= '0;
      selQ      <= '0;
      ackQ      <= '0;
      rdataQ    <= '0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memDataQ  <= '0;
      procDoneQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      ptrQ      <= ptrD;
      selQ      <= selD;
      ackQ      <= ackD;
      rdataQ    <= rdataD;
      memWeQ    <= memWeD;
      memAddrQ  <= memAddrD;
      memDataQ  <= memDataD;
      procDoneQ <= &bus.coreDone;
    end
  end

  assign bus.ack     = ackQ;
  assign bus.rdata   = rdataQ;
  assign mem_writeEn = memWeQ;
  assign mem_address = memAddrQ;
  assign mem_dataIn  = memDataQ;
  assign processDone = procDoneQ;

endmodule
